// File: rtl/io_display.sv
// io_display: 14-bit word to 4-digit common-anode 7-segment display via shift-add-3 BCD conversion.
// Define IO_DISPLAY_LZB_EN to blank leading zero digits.
module io_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        busy,
    output logic        ovf
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [6:0] ZERO = 7'b1000000;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t      st_q, st_d;
    logic [13:0] cap_q, cap_d;
    logic [33:0] sh_q, sh_d, adj;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  dig_q [4];
    logic [6:0]  dig_d [4];
    logic        ovf_q, ovf_d, busy_q, busy_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
`ifdef IO_DISPLAY_LZB_EN
    logic        lz;
`endif

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'd0: enc = 7'b1000000;
            4'd1: enc = 7'b1111001;
            4'd2: enc = 7'b0100100;
            4'd3: enc = 7'b0110000;
            4'd4: enc = 7'b0011001;
            4'd5: enc = 7'b0010010;
            4'd6: enc = 7'b0000010;
            4'd7: enc = 7'b1111000;
            4'd8: enc = 7'b0000000;
            4'd9: enc = 7'b0010000;
            default: enc = BLANK;
        endcase
    endfunction

    always_comb begin
        st_d = st_q;
        cap_d = cap_q;
        sh_d = sh_q;
        cnt_d = cnt_q;
        dig_d = dig_q;
        ovf_d = ovf_q;
        adj = sh_q;
`ifdef IO_DISPLAY_LZB_EN
        lz = 1'b1;
`endif
        // BCD nibbles live above the 14 binary bits
        for (int k = 0; k < 5; k++)
            if (adj[14+4*k +: 4] >= 4'd5) adj[14+4*k +: 4] = adj[14+4*k +: 4] + 4'd3;
        case (st_q)
            IDLE: if (value != cap_q) begin
                cap_d = value;
                sh_d = {20'b0, value};
                cnt_d = 4'd0;
                st_d = CONV;
            end
            CONV: begin
                sh_d = adj << 1;
                cnt_d = cnt_q + 4'd1;
                st_d = cnt_q == 4'd13 ? UPDATE : CONV;
            end
            UPDATE: begin
                ovf_d = cap_q > 14'd9999;
                for (int k = 3; k >= 0; k--) begin
`ifdef IO_DISPLAY_LZB_EN
                    lz = lz && sh_q[14+4*k +: 4] == 4'd0 && k != 0;
                    dig_d[k] = ovf_d ? DASH : lz ? BLANK : enc(sh_q[14+4*k +: 4]);
`else
                    dig_d[k] = ovf_d ? DASH : enc(sh_q[14+4*k +: 4]);
`endif
                end
                st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
        busy_d = st_d != IDLE;
    end

    always_comb begin
        pre_d = pre_q == PW'(REFRESH_DIV - 1) ? '0 : pre_q + 1'b1;
        idx_d = pre_q == PW'(REFRESH_DIV - 1) ? idx_q + 2'd1 : idx_q;
        an_d = ~(4'b0001 << idx_d);
        seg_d = dig_q[idx_d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q <= IDLE;
            cap_q <= '0;
            sh_q <= '0;
            cnt_q <= '0;
            dig_q <= '{default: ZERO};
            ovf_q <= 1'b0;
            busy_q <= 1'b0;
            pre_q <= '0;
            idx_q <= '0;
            an_q <= 4'b1110;
            seg_q <= ZERO;
        end else begin
            st_q <= st_d;
            cap_q <= cap_d;
            sh_q <= sh_d;
            cnt_q <= cnt_d;
            dig_q <= dig_d;
            ovf_q <= ovf_d;
            busy_q <= busy_d;
            pre_q <= pre_d;
            idx_q <= idx_d;
            an_q <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an = an_q;
    assign seg = seg_q;
    assign busy = busy_q;
    assign ovf = ovf_q;
endmodule
